// File: rtl/point_add_seq_pkg.sv
// Shared definitions for the GF(3^M) elliptic-curve point adder.
// Digits are 2-bit codes (00=0, 01=1, 10=2); 11 is never produced.
package point_add_seq_pkg;

  localparam logic [1:0] ZERO = 2'b00;
  localparam logic [1:0] ONE  = 2'b01;
  localparam logic [1:0] TWO  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    INV,
    LAMBDA,
    XOUT,
    YOUT,
    FINISH
  } state_t;

  // Sub-steps of the inversion ladder: d^2 seed, then square / cube / digit multiply.
  typedef enum logic [1:0] {
    PH_D2,
    PH_SQ,
    PH_CU,
    PH_ML
  } inv_ph_t;

  function automatic logic [1:0] dig_neg(input logic [1:0] a);
    case (a)
      ONE:     return TWO;
      TWO:     return ONE;
      default: return ZERO;
    endcase
  endfunction

  function automatic logic [1:0] dig_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] dig_sub(input logic [1:0] a, input logic [1:0] b);
    return dig_add(a, dig_neg(b));
  endfunction

  function automatic logic [1:0] dig_mul(input logic [1:0] a, input logic [1:0] d);
    case (d)
      ONE:     return a;
      TWO:     return dig_neg(a);
      default: return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/point_add_seq_gf3m_mul.sv
// Digit-serial GF(3^M) multiplier, MSB digit of b first, reduced by x^M = 2x^K + 1.
// start accepted when idle; done pulses M+1 cycles later and p holds until the next start.
module gf3m_mul
  import point_add_seq_pkg::*;
#(
  parameter int M = 97,
  parameter int K = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*M-1:0] a,
  input  logic [2*M-1:0] b,
  output logic           done,
  output logic [2*M-1:0] p
);

  localparam int W  = 2 * M;
  localparam int CW = $clog2(M + 1);

  logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [W-1:0]  sh;
  logic [1:0]    top, bd;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    sh     = '0;
    top    = ZERO;
    bd     = ZERO;
    if (cnt_q != '0) begin
      // acc*x with the overflowing coefficient folded back into x^K and x^0
      top = acc_q[W-1 -: 2];
      sh  = {acc_q[W-3:0], 2'b00};
      sh[1:0] = top;
      sh[2*K+1 -: 2] = dig_add(sh[2*K+1 -: 2], dig_neg(top));
      bd  = b_q[W-1 -: 2];
      for (int i = 0; i < M; i++) begin
        acc_d[2*i +: 2] = dig_add(sh[2*i +: 2], dig_mul(a_q[2*i +: 2], bd));
      end
      b_d    = {b_q[W-3:0], 2'b00};
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end else if (start) begin
      a_d   = a;
      b_d   = b;
      acc_d = '0;
      cnt_d = CW'(M);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign p    = acc_q;

endmodule

// File: rtl/point_add_seq.sv
// Affine point addition on y^2 = x^3 - x + 1 over GF(3^M) with one shared multiplier.
// Special cases finish 2 cycles after start; general adds take (3M+1) products of M+1 cycles.
module point_add_seq
  import point_add_seq_pkg::*;
#(
  parameter int M = 97,
  parameter int K = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*M-1:0] x1,
  input  logic [2*M-1:0] y1,
  input  logic [2*M-1:0] x2,
  input  logic [2*M-1:0] y2,
  input  logic           zero1,
  input  logic           zero2,
  output logic           busy,
  output logic           done,
  output logic [2*M-1:0] x3,
  output logic [2*M-1:0] y3,
  output logic           zero3
);

  localparam int W  = 2 * M;
  localparam int CW = $clog2(M + 1);
  localparam logic [W-1:0] ONE_EL = {{(W-2){1'b0}}, ONE};

  state_t        state_q, state_d;
  inv_ph_t       ph_q, ph_d;
  logic [CW-1:0] dig_q, dig_d;
  logic [W-1:0]  x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic          z1_q, z1_d, z2_q, z2_d;
  logic [W-1:0]  d_q, d_d, n_q, n_d, d2_q, d2_d, r_q, r_d;
  logic [W-1:0]  lam_q, lam_d, xw_q, xw_d, x3_q, x3_d, y3_q, y3_d;
  logic          zero3_q, zero3_d;
  logic          mul_start, mul_done;
  logic [W-1:0]  mul_a, mul_b, mul_p, xdiff, ydiff, xnew;

  function automatic logic [W-1:0] el_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = dig_sub(a[2*i +: 2], b[2*i +: 2]);
    return r;
  endfunction

  gf3m_mul #(.M(M), .K(K)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    dig_d     = dig_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    x2_d      = x2_q;
    y2_d      = y2_q;
    z1_d      = z1_q;
    z2_d      = z2_q;
    d_d       = d_q;
    n_d       = n_q;
    d2_d      = d2_q;
    r_d       = r_q;
    lam_d     = lam_q;
    xw_d      = xw_q;
    x3_d      = x3_q;
    y3_d      = y3_q;
    zero3_d   = zero3_q;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    xdiff     = el_sub(x2_q, x1_q);
    ydiff     = el_sub(y2_q, y1_q);
    xnew      = el_sub(el_sub(mul_p, x1_q), x2_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          x1_d    = x1;
          y1_d    = y1;
          x2_d    = x2;
          y2_d    = y2;
          z1_d    = zero1;
          z2_d    = zero2;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        state_d = FINISH;
        if (z1_q && z2_q) begin
          x3_d    = '0;
          y3_d    = '0;
          zero3_d = 1'b1;
        end else if (z1_q) begin
          x3_d    = x2_q;
          y3_d    = y2_q;
          zero3_d = 1'b0;
        end else if (z2_q) begin
          x3_d    = x1_q;
          y3_d    = y1_q;
          zero3_d = 1'b0;
        end else if (x1_q == x2_q) begin
          // Tangent slope on this curve reduces to 1/y1; P2 = -P1 or y1 = 0 gives infinity
          if (y1_q == y2_q && y1_q != '0) begin
            d_d       = y1_q;
            n_d       = ONE_EL;
            mul_start = 1'b1;
            mul_a     = y1_q;
            mul_b     = y1_q;
            ph_d      = PH_D2;
            state_d   = INV;
          end else begin
            x3_d    = '0;
            y3_d    = '0;
            zero3_d = 1'b1;
          end
        end else begin
          d_d       = xdiff;
          n_d       = ydiff;
          mul_start = 1'b1;
          mul_a     = xdiff;
          mul_b     = xdiff;
          ph_d      = PH_D2;
          state_d   = INV;
        end
      end
      INV: begin
        if (mul_done) begin
          mul_start = 1'b1;
          mul_a     = mul_p;
          case (ph_q)
            PH_D2: begin
              // Leading exponent digit is 2, so the ladder starts at r = d^2
              d2_d  = mul_p;
              r_d   = mul_p;
              dig_d = CW'(M - 1);
              mul_b = mul_p;
              ph_d  = PH_SQ;
            end
            PH_SQ: begin
              mul_b = r_q;
              ph_d  = PH_CU;
            end
            PH_CU: begin
              mul_b = (dig_q == CW'(1)) ? d_q : d2_q;
              ph_d  = PH_ML;
            end
            default: begin
              r_d = mul_p;
              if (dig_q == CW'(1)) begin
                mul_a   = n_q;
                mul_b   = mul_p;
                state_d = LAMBDA;
              end else begin
                dig_d = dig_q - CW'(1);
                mul_b = mul_p;
                ph_d  = PH_SQ;
              end
            end
          endcase
        end
      end
      LAMBDA: begin
        if (mul_done) begin
          lam_d     = mul_p;
          mul_start = 1'b1;
          mul_a     = mul_p;
          mul_b     = mul_p;
          state_d   = XOUT;
        end
      end
      XOUT: begin
        if (mul_done) begin
          xw_d      = xnew;
          mul_start = 1'b1;
          mul_a     = lam_q;
          mul_b     = el_sub(x1_q, xnew);
          state_d   = YOUT;
        end
      end
      YOUT: begin
        if (mul_done) begin
          x3_d    = xw_q;
          y3_d    = el_sub(mul_p, y1_q);
          zero3_d = 1'b0;
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ph_q    <= PH_D2;
      dig_q   <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      z1_q    <= 1'b0;
      z2_q    <= 1'b0;
      d_q     <= '0;
      n_q     <= '0;
      d2_q    <= '0;
      r_q     <= '0;
      lam_q   <= '0;
      xw_q    <= '0;
      x3_q    <= '0;
      y3_q    <= '0;
      zero3_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      dig_q   <= dig_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      z1_q    <= z1_d;
      z2_q    <= z2_d;
      d_q     <= d_d;
      n_q     <= n_d;
      d2_q    <= d2_d;
      r_q     <= r_d;
      lam_q   <= lam_d;
      xw_q    <= xw_d;
      x3_q    <= x3_d;
      y3_q    <= y3_d;
      zero3_q <= zero3_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == FINISH);
  assign x3    = x3_q;
  assign y3    = y3_q;
  assign zero3 = zero3_q;

endmodule

// File: tb/tb_point_add_seq.sv
// Scoreboard bench for point_add_seq over GF(3^5) with x^5 + x^4 + 2 (irreducible).
module tb_point_add_seq;

  localparam int M     = 5;
  localparam int K     = 4;
  localparam int W     = 2 * M;
  localparam int NF    = 3 ** M;
  localparam int BOUND = (3 * M + 4) * (M + 2) + 4;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         z;
  } res_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic         zero1 = 1'b0, zero2 = 1'b0;
  logic         busy, done, zero3;
  logic [W-1:0] x3, y3;

  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  point_add_seq #(.M(M), .K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x1    (x1),
    .y1    (y1),
    .x2    (x2),
    .y2    (y2),
    .zero1 (zero1),
    .zero2 (zero2),
    .busy  (busy),
    .done  (done),
    .x3    (x3),
    .y3    (y3),
    .zero3 (zero3)
  );

  // ---------------- reference field / curve model ----------------
  function automatic logic [W-1:0] el(input int v);
    logic [W-1:0] r;
    r = '0;
    r[1:0] = 2'(v);
    return r;
  endfunction

  function automatic res_t mk(input logic [W-1:0] x, input logic [W-1:0] y, input logic z);
    res_t r;
    r.x = x;
    r.y = y;
    r.z = z;
    return r;
  endfunction

  function automatic logic [W-1:0] m_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'((int'(a[2*i +: 2]) + int'(b[2*i +: 2])) % 3);
    return r;
  endfunction

  function automatic logic [W-1:0] m_neg(input logic [W-1:0] a);
    logic [W-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'((3 - int'(a[2*i +: 2])) % 3);
    return r;
  endfunction

  function automatic logic [W-1:0] m_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return m_add(a, m_neg(b));
  endfunction

  function automatic logic [W-1:0] m_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int t[2*M-1];
    logic [W-1:0] r;
    foreach (t[i]) t[i] = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        t[i+j] += int'(a[2*i +: 2]) * int'(b[2*j +: 2]);
    for (int k = 2*M-2; k >= M; k--) begin
      t[k-M+K] += 2 * t[k];
      t[k-M]   += t[k];
      t[k]      = 0;
    end
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(t[i] % 3);
    return r;
  endfunction

  function automatic logic [W-1:0] m_from_int(input int v);
    int q;
    logic [W-1:0] r;
    q = v;
    r = '0;
    for (int i = 0; i < M; i++) begin
      r[2*i +: 2] = 2'(q % 3);
      q = q / 3;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] m_inv(input logic [W-1:0] a);
    logic [W-1:0] b, r;
    r = '0;
    for (int v = 1; v < NF; v++) begin
      b = m_from_int(v);
      if (m_mul(a, b) == el(1)) r = b;
    end
    return r;
  endfunction

  function automatic bit has_illegal(input logic [W-1:0] v);
    bit r;
    r = 1'b0;
    for (int i = 0; i < M; i++) if (v[2*i +: 2] === 2'b11) r = 1'b1;
    return r;
  endfunction

  task automatic gen_point(output logic [W-1:0] px, output logic [W-1:0] py);
    logic [W-1:0] rhs, b;
    bit found;
    found = 1'b0;
    px = '0;
    py = '0;
    while (!found) begin
      px  = m_from_int(int'($urandom_range(NF - 1, 0)));
      rhs = m_add(m_sub(m_mul(m_mul(px, px), px), px), el(1));
      for (int v = 0; v < NF; v++) begin
        b = m_from_int(v);
        if (!found && m_mul(b, b) == rhs) begin
          py = b;
          found = 1'b1;
        end
      end
    end
    if ($urandom_range(1, 0) == 1) py = m_neg(py);
  endtask

  task automatic model_add(input logic [W-1:0] ax, input logic [W-1:0] ay, input logic za,
                           input logic [W-1:0] bx, input logic [W-1:0] by, input logic zb,
                           output logic [W-1:0] rx, output logic [W-1:0] ry, output logic rz);
    logic [W-1:0] lam;
    bit inf;
    inf = 1'b0;
    lam = '0;
    rx  = '0;
    ry  = '0;
    rz  = 1'b0;
    if (za && zb) begin
      rz = 1'b1;
    end else if (za) begin
      rx = bx;
      ry = by;
    end else if (zb) begin
      rx = ax;
      ry = ay;
    end else begin
      if (ax == bx) begin
        if (ay == by && ay != '0) lam = m_mul(m_sub(m_mul(el(3 - 3), ax), el(1)), m_inv(m_add(ay, ay)));
        else inf = 1'b1;
      end else begin
        lam = m_mul(m_sub(by, ay), m_inv(m_sub(bx, ax)));
      end
      if (inf) begin
        rz = 1'b1;
      end else begin
        rx = m_sub(m_sub(m_mul(lam, lam), ax), bx);
        ry = m_sub(m_mul(lam, m_sub(ax, rx)), ay);
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [W-1:0] ax, input logic [W-1:0] ay, input logic za,
                             input logic [W-1:0] bx, input logic [W-1:0] by, input logic zb);
    x1    = ax;
    y1    = ay;
    zero1 = za;
    x2    = bx;
    y2    = by;
    zero2 = zb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc, output bit ok);
    cyc = 1;
    while (done !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
    ok = (done === 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    zero1 = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b, expected 0 0", busy, done);
    end
    checks++;
    if (x3 !== '0 || y3 !== '0 || zero3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: x3=%h y3=%h zero3=%b, expected 0 0 0", x3, y3, zero3);
    end
    start = 1'b0;
    zero1 = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_special();
    logic [W-1:0] ax[4], ay[4], bx[4], by[4];
    logic za[4], zb[4];
    int cyc;
    bit ok;
    res_t e;
    ax[0] = el(2); ay[0] = el(2); za[0] = 1'b1; bx[0] = el(1); by[0] = el(1); zb[0] = 1'b0;
    ax[1] = el(2); ay[1] = el(1); za[1] = 1'b0; bx[1] = el(0); by[1] = el(1); zb[1] = 1'b1;
    ax[2] = el(1); ay[2] = el(1); za[2] = 1'b1; bx[2] = el(2); by[2] = el(2); zb[2] = 1'b1;
    ax[3] = el(0); ay[3] = el(1); za[3] = 1'b0; bx[3] = el(0); by[3] = el(2); zb[3] = 1'b0;
    exp_q.push_back(mk(el(1), el(1), 1'b0));
    exp_q.push_back(mk(el(2), el(1), 1'b0));
    exp_q.push_back(mk('0, '0, 1'b1));
    exp_q.push_back(mk('0, '0, 1'b1));
    for (int c = 0; c < 4; c++) begin
      drive_start(ax[c], ay[c], za[c], bx[c], by[c], zb[c]);
      wait_done(BOUND + 5, cyc, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || cyc != 2) begin
        errors++;
        $display("FAIL special%0d_latency: done after %0d cycles (seen=%b), expected 2", c, cyc, ok);
      end
      checks++;
      if (x3 !== e.x || y3 !== e.y || zero3 !== e.z) begin
        errors++;
        $display("FAIL special%0d_result: got %h,%h,%b expected %h,%h,%b", c, x3, y3, zero3, e.x, e.y, e.z);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL special%0d_pulse: done=%b busy=%b after done, expected 0 0", c, done, busy);
      end
    end
  endtask

  task automatic test_general();
    logic [W-1:0] ax[3], ay[3], bx[3], by[3];
    int cyc;
    bit ok;
    res_t e;
    ax[0] = el(0); ay[0] = el(1); bx[0] = el(0); by[0] = el(1);
    ax[1] = el(0); ay[1] = el(1); bx[1] = el(1); by[1] = el(1);
    ax[2] = el(1); ay[2] = el(1); bx[2] = el(0); by[2] = el(1);
    exp_q.push_back(mk(el(1), el(1), 1'b0));
    exp_q.push_back(mk(el(2), el(2), 1'b0));
    exp_q.push_back(mk(el(2), el(2), 1'b0));
    for (int c = 0; c < 3; c++) begin
      drive_start(ax[c], ay[c], 1'b0, bx[c], by[c], 1'b0);
      wait_done(BOUND + 5, cyc, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || cyc > BOUND) begin
        errors++;
        $display("FAIL general%0d_latency: %0d cycles (seen=%b), limit %0d", c, cyc, ok, BOUND);
      end
      checks++;
      if (x3 !== e.x || y3 !== e.y || zero3 !== e.z) begin
        errors++;
        $display("FAIL general%0d_result: got %h,%h,%b expected %h,%h,%b", c, x3, y3, zero3, e.x, e.y, e.z);
      end
      tick();
    end
  endtask

  task automatic test_input_change();
    int cyc;
    bit ok;
    res_t e;
    exp_q.push_back(mk(el(2), el(2), 1'b0));
    drive_start(el(0), el(1), 1'b0, el(1), el(1), 1'b0);
    x1 = el(2);
    y1 = el(2);
    zero2 = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    start = 1'b0;
    wait_done(BOUND + 5, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || x3 !== e.x || y3 !== e.y || zero3 !== e.z) begin
      errors++;
      $display("FAIL latch_inputs: seen=%b got %h,%h,%b expected %h,%h,%b", ok, x3, y3, zero3, e.x, e.y, e.z);
    end
    zero1 = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL finish_start_ignored: busy=%b, expected 0", busy);
    end
    tick();
    tick();
    checks++;
    if (x3 !== e.x || y3 !== e.y || zero3 !== e.z || busy !== 1'b0) begin
      errors++;
      $display("FAIL output_hold: got %h,%h,%b busy=%b expected %h,%h,%b busy=0", x3, y3, zero3, busy, e.x, e.y, e.z);
    end
    zero1 = 1'b0;
    zero2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok, seen;
    res_t e;
    drive_start(el(0), el(1), 1'b0, el(1), el(1), 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    checks++;
    if (seen || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_ctrl: early_done=%b done=%b busy=%b, expected 0 0 0", seen, done, busy);
    end
    checks++;
    if (x3 !== '0 || y3 !== '0 || zero3 !== 1'b0) begin
      errors++;
      $display("FAIL abort_out: x3=%h y3=%h zero3=%b, expected 0 0 0", x3, y3, zero3);
    end
    reset = 1'b0;
    exp_q.push_back(mk(el(1), el(1), 1'b0));
    drive_start(el(0), el(1), 1'b0, el(0), el(1), 1'b0);
    wait_done(BOUND + 5, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || cyc > BOUND || x3 !== e.x || y3 !== e.y || zero3 !== e.z) begin
      errors++;
      $display("FAIL restart: seen=%b cycles=%0d got %h,%h,%b expected %h,%h,%b", ok, cyc, x3, y3, zero3, e.x, e.y, e.z);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] ax, ay, bx, by, ex, ey;
    logic za, zb, ez;
    int mode, cyc;
    bit ok;
    res_t e;
    for (int n = 0; n < 40; n++) begin
      gen_point(ax, ay);
      gen_point(bx, by);
      za = 1'b0;
      zb = 1'b0;
      mode = int'($urandom_range(9, 0));
      if (mode == 0) za = 1'b1;
      else if (mode == 1) zb = 1'b1;
      else if (mode == 2) begin bx = ax; by = ay; end
      else if (mode == 3) begin bx = ax; by = m_neg(ay); end
      model_add(ax, ay, za, bx, by, zb, ex, ey, ez);
      exp_q.push_back(mk(ex, ey, ez));
      drive_start(ax, ay, za, bx, by, zb);
      wait_done(BOUND + 5, cyc, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || cyc > BOUND) begin
        errors++;
        $display("FAIL rand%0d_latency: %0d cycles (seen=%b), limit %0d", n, cyc, ok, BOUND);
      end
      checks++;
      if (x3 !== e.x || y3 !== e.y || zero3 !== e.z) begin
        errors++;
        $display("FAIL rand%0d_result mode %0d: got %h,%h,%b expected %h,%h,%b", n, mode, x3, y3, zero3, e.x, e.y, e.z);
      end
      checks++;
      if (has_illegal(x3) || has_illegal(y3)) begin
        errors++;
        $display("FAIL rand%0d_encoding: x3=%h y3=%h contain digit 11, expected none", n, x3, y3);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_special();
    test_general();
    test_input_change();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
